// File: rtl/aes128_encrypt_core_if.sv
// Block-level bus for aes128_encrypt_core: start request, plaintext/key words, ciphertext, status.
// Define AES_LAST_KEY_EN to carry the final round key alongside the ciphertext.
interface aes128_encrypt_core_if;
  logic        start;
  logic [31:0] data_0, data_1, data_2, data_3;
  logic [31:0] key_0, key_1, key_2, key_3;
  logic [31:0] dout_0, dout_1, dout_2, dout_3;
  logic        busy;
  logic        done;
`ifdef AES_LAST_KEY_EN
  logic [31:0] key_out_0, key_out_1, key_out_2, key_out_3;

  modport master (
    output start, data_0, data_1, data_2, data_3, key_0, key_1, key_2, key_3,
    input  dout_0, dout_1, dout_2, dout_3, busy, done,
    input  key_out_0, key_out_1, key_out_2, key_out_3
  );
  modport slave (
    input  start, data_0, data_1, data_2, data_3, key_0, key_1, key_2, key_3,
    output dout_0, dout_1, dout_2, dout_3, busy, done,
    output key_out_0, key_out_1, key_out_2, key_out_3
  );
`else
  modport master (
    output start, data_0, data_1, data_2, data_3, key_0, key_1, key_2, key_3,
    input  dout_0, dout_1, dout_2, dout_3, busy, done
  );
  modport slave (
    input  start, data_0, data_1, data_2, data_3, key_0, key_1, key_2, key_3,
    output dout_0, dout_1, dout_2, dout_3, busy, done
  );
`endif
endinterface

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 cipher: one round per clock, round keys expanded on the fly.
// Optional AES_LAST_KEY_EN exports the round-10 key with each ciphertext.
module aes128_encrypt_core (
  input  logic                  clk,
  input  logic                  rst,
  aes128_encrypt_core_if.slave  bus
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] inv;
    t   = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] state_r;
  logic [127:0] rkey_r;
  logic [3:0]   round_r;
  logic         busy_r;
  logic         done_r;
  logic [127:0] dout_r;
`ifdef AES_LAST_KEY_EN
  logic [127:0] key_out_r;
`endif

  logic [127:0] sr_s;
  logic [127:0] mc_s;
  logic [127:0] next_key_s;
  logic [127:0] round_out_s;
  logic [31:0]  key_temp_s;
  logic [31:0]  nk0_s, nk1_s, nk2_s, nk3_s;

  // One cipher round plus the matching key-expansion step; byte b sits at [127-8b -: 8].
  always_comb begin
    sr_s = '0;
    mc_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[127 - 8*(4*c + r) -: 8] = sbox(state_r[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[127 - 32*c -: 32] = mix_col(sr_s[127 - 32*c -: 32]);
    end
    key_temp_s = {sbox(rkey_r[23:16]), sbox(rkey_r[15:8]), sbox(rkey_r[7:0]), sbox(rkey_r[31:24])}
                 ^ {rcon(round_r), 24'h000000};
    nk0_s      = rkey_r[127:96] ^ key_temp_s;
    nk1_s      = rkey_r[95:64]  ^ nk0_s;
    nk2_s      = rkey_r[63:32]  ^ nk1_s;
    nk3_s      = rkey_r[31:0]   ^ nk2_s;
    next_key_s = {nk0_s, nk1_s, nk2_s, nk3_s};
    if (round_r == 4'd10) begin
      round_out_s = sr_s ^ next_key_s;
    end else begin
      round_out_s = mc_s ^ next_key_s;
    end
  end

  // Load, iterate and retire blocks; start is only honoured while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= 128'h0;
      rkey_r    <= 128'h0;
      round_r   <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dout_r    <= 128'h0;
`ifdef AES_LAST_KEY_EN
      key_out_r <= 128'h0;
`endif
    end else begin
      done_r <= 1'b0;
      if (busy_r) begin
        state_r <= round_out_s;
        rkey_r  <= next_key_s;
        if (round_r == 4'd10) begin
          dout_r    <= round_out_s;
`ifdef AES_LAST_KEY_EN
          key_out_r <= next_key_s;
`endif
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          round_r   <= 4'd0;
        end else begin
          round_r <= round_r + 4'd1;
        end
      end else if (bus.start) begin
        state_r <= {bus.data_0, bus.data_1, bus.data_2, bus.data_3}
                   ^ {bus.key_0, bus.key_1, bus.key_2, bus.key_3};
        rkey_r  <= {bus.key_0, bus.key_1, bus.key_2, bus.key_3};
        round_r <= 4'd1;
        busy_r  <= 1'b1;
      end else begin
        round_r <= round_r;
      end
    end
  end

  assign bus.dout_0 = dout_r[127:96];
  assign bus.dout_1 = dout_r[95:64];
  assign bus.dout_2 = dout_r[63:32];
  assign bus.dout_3 = dout_r[31:0];
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
`ifdef AES_LAST_KEY_EN
  assign bus.key_out_0 = key_out_r[127:96];
  assign bus.key_out_1 = key_out_r[95:64];
  assign bus.key_out_2 = key_out_r[63:32];
  assign bus.key_out_3 = key_out_r[31:0];
`endif

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed-vector bench for aes128_encrypt_core using FIPS-197 known answers.
module tb_aes128_encrypt_core;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  aes128_encrypt_core_if bus ();

  aes128_encrypt_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_DATA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_OUT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_LAST = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] Z_OUT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_DATA  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_OUT   = 128'h3925841d02dc09fbdc118597196a0b32;

  function automatic logic [127:0] dout_now();
    return {bus.dout_0, bus.dout_1, bus.dout_2, bus.dout_3};
  endfunction

  task automatic drive_words(input logic [127:0] d, input logic [127:0] k);
    {bus.data_0, bus.data_1, bus.data_2, bus.data_3} = d;
    {bus.key_0, bus.key_1, bus.key_2, bus.key_3}     = k;
  endtask

  // Returns at the negedge right after the edge that sampled start.
  task automatic kick(input logic [127:0] d, input logic [127:0] k);
    @(negedge clk);
    drive_words(d, k);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges from the start edge (counted as 1) until done is seen; 40 means timeout.
  task automatic wait_done(output int edges);
    edges = 1;
    while (bus.done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    drive_words(C1_DATA, C1_KEY);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    checks++;
    if (dout_now() !== 128'h0) begin
      errors++;
      $display("FAIL reset_dout got %h required 0", dout_now());
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_c1();
    int edges;
    kick(C1_DATA, C1_KEY);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL c1_busy got %b required 1", bus.busy);
    end
    wait_done(edges);
    checks++;
    if (edges !== 11) begin
      errors++;
      $display("FAIL c1_latency got %0d required 11", edges);
    end
    checks++;
    if (dout_now() !== C1_OUT || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL c1_dout got %h busy=%b required %h busy=0", dout_now(), bus.busy, C1_OUT);
    end
`ifdef AES_LAST_KEY_EN
    checks++;
    if ({bus.key_out_0, bus.key_out_1, bus.key_out_2, bus.key_out_3} !== C1_LAST) begin
      errors++;
      $display("FAIL c1_last_key got %h required %h",
               {bus.key_out_0, bus.key_out_1, bus.key_out_2, bus.key_out_3}, C1_LAST);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || dout_now() !== C1_OUT) begin
      errors++;
      $display("FAIL c1_hold done=%b dout=%h required 0 %h", bus.done, dout_now(), C1_OUT);
    end
  endtask

  task automatic test_zero();
    int edges;
    kick(128'h0, 128'h0);
    wait_done(edges);
    checks++;
    if (edges !== 11 || dout_now() !== Z_OUT) begin
      errors++;
      $display("FAIL zero_vector got %h after %0d required %h after 11", dout_now(), edges, Z_OUT);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    kick(B_DATA, B_KEY);
    wait_done(edges);
    checks++;
    if (edges !== 11 || dout_now() !== B_OUT) begin
      errors++;
      $display("FAIL b2b_first got %h after %0d required %h after 11", dout_now(), edges, B_OUT);
    end
    // New request presented in the done cycle itself.
    drive_words(C1_DATA, C1_KEY);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept busy=%b required 1", bus.busy);
    end
    wait_done(edges);
    checks++;
    if (edges !== 11 || dout_now() !== C1_OUT) begin
      errors++;
      $display("FAIL b2b_second got %h after %0d required %h after 11", dout_now(), edges, C1_OUT);
    end
  endtask

  task automatic test_ignore_start();
    int n_done;
    int first_done;
    n_done = 0;
    first_done = 0;
    kick(C1_DATA, C1_KEY);
    for (int e = 1; e <= 25; e++) begin
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = e;
      end
      if (e == 3 || e == 7) begin
        drive_words(B_DATA, B_KEY);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (n_done !== 1 || first_done !== 11) begin
      errors++;
      $display("FAIL ignore_done count=%0d first=%0d required 1 11", n_done, first_done);
    end
    checks++;
    if (dout_now() !== C1_OUT || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_dout got %h busy=%b required %h busy=0", dout_now(), bus.busy, C1_OUT);
    end
  endtask

  task automatic test_mid_reset();
    int n_done;
    int edges;
    n_done = 0;
    kick(B_DATA, B_KEY);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || dout_now() !== 128'h0) begin
      errors++;
      $display("FAIL midrst_state busy=%b done=%b dout=%h required 0 0 0", bus.busy, bus.done, dout_now());
    end
    for (int e = 0; e < 12; e++) begin
      if (bus.done === 1'b1) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL midrst_no_done count=%0d required 0", n_done);
    end
    kick(C1_DATA, C1_KEY);
    wait_done(edges);
    checks++;
    if (edges !== 11 || dout_now() !== C1_OUT) begin
      errors++;
      $display("FAIL midrst_restart got %h after %0d required %h after 11", dout_now(), edges, C1_OUT);
    end
  endtask

  task automatic test_input_change();
    int edges;
    @(negedge clk);
    drive_words(C1_DATA, C1_KEY);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drive_words({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    wait_done(edges);
    checks++;
    if (edges !== 11 || dout_now() !== C1_OUT) begin
      errors++;
      $display("FAIL input_change got %h after %0d required %h after 11", dout_now(), edges, C1_OUT);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    drive_words(128'h0, 128'h0);
    test_reset();
    test_c1();
    test_zero();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
    test_input_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_core.md
Name: aes128_encrypt_core

Overview:
- Iterative AES-128 encryption core (FIPS-197, cipher direction only).
- Takes a 128-bit plaintext block and a 128-bit key, each as four 32-bit words, and produces a 128-bit ciphertext as four 32-bit words.
- Executes one round per clock with an on-the-fly key schedule.
- Sits as the block-cipher primitive under higher-level crypto/mode logic.

Parameters:
- None. Key size is fixed at 128 bits and round count is fixed at 10.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request; samples data_*/key_* when core is idle
- data_0..data_3  input  32 each  plaintext words; data_0[31:24] is state byte 0, data_3[7:0] is byte 15
- key_0..key_3  input  32 each  cipher key words, same byte order as data
- dout_0..dout_3  output  32 each  ciphertext words, same byte order
- busy  output  1  high while a block is in progress
- done  output  1  one-cycle pulse when dout_* is updated

Behaviour:
- Reset (rst high at a clock edge): busy=0, done=0, dout_0..3=0, round counter=0, internal state and round key cleared. Reset takes priority over every other input.
- Column mapping: word i is state column i. Byte b of the state maps to row b%4, column b/4 (FIPS-197 column-major order).
- Load: on an edge with start=1 and busy=0:
  - state <= data XOR key (initial AddRoundKey)
  - round key register <= key
  - round counter <= 1
  - busy <= 1
- Round r = 1..9, one per cycle: SubBytes, ShiftRows, MixColumns, then AddRoundKey with round key r.
- Round key r is derived combinationally from round key r-1 in the same cycle: RotWord, SubWord, XOR with Rcon[r]. Rcon sequence: 01,02,04,08,10,20,40,80,1b,36 placed in the top byte.
- Round 10: SubBytes, ShiftRows, AddRoundKey. No MixColumns.
- Completion: the round-10 result is written to dout_0..3 on the same edge, with done=1 for exactly that one cycle and busy=0 on that edge.
- Latency: done is asserted 11 clock edges after the start edge.
- Throughput: a new start is accepted in the cycle done is high, giving back-to-back blocks every 11 cycles.
- start while busy=1 is ignored. No queuing; inputs are not re-sampled.
- data_*/key_* only need to be valid in the start cycle. They are not sampled afterwards.
- dout_* holds the last ciphertext until the next completion or reset.
- Reset mid-operation aborts the block. done is not asserted and dout returns to 0.
- S-box: combinational, either a 256-entry lookup or GF(2^8) inverse plus affine transform (implementer's choice). Required instances: 16 for state, 4 for key schedule.
- MixColumns uses xtime (left shift, conditional XOR 0x1b).
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: AES_LAST_KEY_EN
- Defined:
  - Adds outputs key_out_0..key_out_3 (32 each), the round-10 key.
  - Updated on the same edge as dout, reset to 0, held otherwise.
  - Intended for seeding an external inverse cipher.
- Undefined: ports absent, no extra registers.

Test Plan:
- FIPS-197 C.1: key 00010203 04050607 08090a0b 0c0d0e0f, data 00112233 44556677 8899aabb ccddeeff, start pulse -> done 11 cycles later, dout 69c4e0d8 6a7b0430 d8cdb780 70b4c55a. With AES_LAST_KEY_EN, key_out 13111d7f e3944a17 f307a78b 4d2b30c5.
- All-zero key and data -> dout 66e94bd4 ef8a2c3b 884cfa59 ca342b2e.
- FIPS-197 App. B: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, data 3243f6a8 885a308d 313198a2 e0370734 -> dout 3925841d 02dc09fb dc118597 196a0b32. Then start again in the done cycle with the C.1 vectors -> second result correct 11 cycles later.
- start pulsed at cycles 3 and 7 after an accepted start, with different data -> only the first block is produced; a single done pulse.
- rst asserted at round 5 -> busy=0, dout=0, no done; a subsequent C.1 start yields the correct ciphertext.
- Inputs changed to random values the cycle after start -> dout still equals the C.1 ciphertext.
